// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and buffers
// returned words so that a {pc, inst} pair (or a NOP bubble) can be presented to IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [SW-1:0] credit;
    logic          req_ok;
    logic          issue;
    logic          keep;
    logic          pop;

    // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
    assign credit         = SW'(out_q) + SW'(count_q);
    assign req_ok         = !redirect && (credit < SW'(DEPTH));
    assign imem_req_valid = reset && req_ok;
    assign imem_addr      = pc_q;
    assign issue          = req_ok && imem_req_ready;

    assign keep     = imem_rsp_valid && !redirect && (drop_q == '0);
    assign if_valid = (count_q != '0);
    assign pop      = if_valid && !stall && !redirect;
    assign if_pc    = if_valid ? fifo_q[rd_q].pc   : 32'h0000_0000;
    assign if_inst  = if_valid ? fifo_q[rd_q].inst : NOP;

    // Next-state logic; redirect overrides issue, push and pop.
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q + CW'(issue) - CW'(imem_rsp_valid);
        drop_d   = drop_q;
        count_d  = count_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        if (redirect) begin
            pc_d     = redirect_pc;
            rsp_pc_d = redirect_pc;
            drop_d   = out_q - CW'(imem_rsp_valid);
            count_d  = '0;
            rd_d     = '0;
            wr_d     = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_d     = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            count_d = count_q + CW'(keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            count_q  <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are live.
    always_ff @(posedge clk) begin
        if (keep) begin
            fifo_q[wr_q] <= entry_t'{pc: rsp_pc_q, inst: imem_rsp_data};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queued imem model feeds the DUT and the presented stream is
// compared against the expected sequence of consecutive PCs from the last redirect target.
module tb_fetch_unit;

    localparam int unsigned DA    = 4;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk;
    logic        rst_a, a_stall, a_redir, a_req_valid, a_ready, a_rsp_valid, a_if_valid;
    logic [31:0] a_redir_pc, a_addr, a_rsp_data, a_if_pc, a_if_inst;
    logic        rst_b, b_req_valid, b_ready, b_rsp_valid, b_if_valid;
    logic        b_stall, b_redir;
    logic [31:0] b_redir_pc, b_addr, b_rsp_data, b_if_pc, b_if_inst;

    int          checks, errors, cyc, g_lat;
    logic        g_stall, g_redir, g_ready;
    logic [31:0] g_redir_pc, exp_pc, last_acc;
    logic        s_rsp, s_req_valid, s_accept, s_if_valid, s_pop;
    logic [31:0] s_addr, s_if_pc, s_if_inst;
    req_t        pend[$];
    logic [31:0] pop_pc[$], pop_inst[$];
    logic        b_prev_acc;
    logic [31:0] b_prev_addr;
    logic [31:0] b_acc[$], b_pop_pc[$], b_pop_inst[$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DA), .NOP(NOP_W)) u_a (
        .clk(clk), .reset(rst_a), .stall(a_stall), .redirect(a_redir), .redirect_pc(a_redir_pc),
        .imem_req_valid(a_req_valid), .imem_req_ready(a_ready), .imem_addr(a_addr),
        .imem_rsp_valid(a_rsp_valid), .imem_rsp_data(a_rsp_data),
        .if_valid(a_if_valid), .if_pc(a_if_pc), .if_inst(a_if_inst)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2), .NOP(NOP_W)) u_b (
        .clk(clk), .reset(rst_b), .stall(b_stall), .redirect(b_redir), .redirect_pc(b_redir_pc),
        .imem_req_valid(b_req_valid), .imem_req_ready(b_ready), .imem_addr(b_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
        .if_valid(b_if_valid), .if_pc(b_if_pc), .if_inst(b_if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // One cycle on instance A: drive at negedge, snapshot, model memory acceptance.
    task automatic tick();
        req_t r;
        int   d;
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r           = pend.pop_front();
            a_rsp_valid = 1'b1;
            a_rsp_data  = memf(r.addr);
        end else begin
            a_rsp_valid = 1'b0;
            a_rsp_data  = 32'hDEAD_BEEF;
        end
        a_stall    = g_stall;
        a_redir    = g_redir;
        a_redir_pc = g_redir_pc;
        a_ready    = g_ready;
        #1;
        s_rsp       = a_rsp_valid;
        s_req_valid = a_req_valid;
        s_addr      = a_addr;
        s_if_valid  = a_if_valid;
        s_if_pc     = a_if_pc;
        s_if_inst   = a_if_inst;
        s_accept    = a_req_valid && a_ready;
        s_pop       = a_if_valid && !a_stall && !a_redir;
        if (s_accept) begin
            d = cyc + g_lat;
            if (pend.size() > 0 && pend[$].due >= d) d = pend[$].due + 1;
            pend.push_back('{addr: a_addr, due: d});
            last_acc = a_addr;
        end
        if (s_pop) begin
            pop_pc.push_back(a_if_pc);
            pop_inst.push_back(a_if_inst);
        end
        @(posedge clk);
        cyc++;
    endtask

    // Stop issuing and let every outstanding word drain out of the buffer.
    task automatic drain(output bit ok);
        ok      = 1'b0;
        g_ready = 1'b0;
        g_stall = 1'b0;
        g_redir = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pend.size() == 0 && !s_if_valid && !s_rsp) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic tick_b();
        @(negedge clk);
        b_rsp_valid = b_prev_acc;
        b_rsp_data  = memf(b_prev_addr);
        b_ready     = 1'b1;
        #1;
        b_prev_acc  = b_req_valid && b_ready;
        b_prev_addr = b_addr;
        if (b_prev_acc) b_acc.push_back(b_addr);
        if (b_if_valid) begin
            b_pop_pc.push_back(b_if_pc);
            b_pop_inst.push_back(b_if_inst);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (a_req_valid !== 1'b0 || a_if_valid !== 1'b0 || a_if_pc !== 32'h0 || a_if_inst !== NOP_W) begin
            errors++;
            $display("FAIL reset_a: got req_valid=%b if_valid=%b pc=%h inst=%h, want 0 0 00000000 %h",
                     a_req_valid, a_if_valid, a_if_pc, a_if_inst, NOP_W);
        end
        checks++;
        if (b_req_valid !== 1'b0 || b_if_valid !== 1'b0 || b_if_inst !== NOP_W) begin
            errors++;
            $display("FAIL reset_b: got req_valid=%b if_valid=%b inst=%h, want 0 0 %h",
                     b_req_valid, b_if_valid, b_if_inst, NOP_W);
        end
        @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] p;
        g_stall = 1'b0; g_redir = 1'b0; g_ready = 1'b1; g_lat = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (s_accept !== 1'b1 || s_addr !== 32'(4 * c)) begin
                errors++;
                $display("FAIL stream_addr c=%0d: got accept=%b addr=%h, want 1 %h", c, s_accept, s_addr, 32'(4 * c));
            end
            checks++;
            if (c < 2) begin
                if (s_if_valid !== 1'b0 || s_if_pc !== 32'h0 || s_if_inst !== NOP_W) begin
                    errors++;
                    $display("FAIL stream_bubble c=%0d: got valid=%b pc=%h inst=%h, want 0 0 %h",
                             c, s_if_valid, s_if_pc, s_if_inst, NOP_W);
                end
            end else begin
                p = 32'(4 * (c - 2));
                if (s_if_valid !== 1'b1 || s_if_pc !== p || s_if_inst !== memf(p)) begin
                    errors++;
                    $display("FAIL stream_head c=%0d: got valid=%b pc=%h inst=%h, want 1 %h %h",
                             c, s_if_valid, s_if_pc, s_if_inst, p, memf(p));
                end
            end
        end
        exp_pc = 32'd40;
    endtask

    task automatic test_stall();
        logic [31:0] hold_pc, hold_inst, inflight;
        g_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                hold_pc   = s_if_pc;
                hold_inst = s_if_inst;
                checks++;
                if (hold_pc !== exp_pc) begin
                    errors++;
                    $display("FAIL stall_head: got pc=%h, want %h", hold_pc, exp_pc);
                end
            end
            checks++;
            if (s_if_valid !== 1'b1 || s_if_pc !== hold_pc || s_if_inst !== hold_inst) begin
                errors++;
                $display("FAIL stall_hold i=%0d: got valid=%b pc=%h inst=%h, want 1 %h %h",
                         i, s_if_valid, s_if_pc, s_if_inst, hold_pc, hold_inst);
            end
        end
        inflight = (s_addr - hold_pc) >> 2;
        checks++;
        if (s_req_valid !== 1'b0 || inflight !== 32'(DA)) begin
            errors++;
            $display("FAIL stall_credit: got req_valid=%b inflight=%0d, want 0 %0d", s_req_valid, inflight, DA);
        end
        g_stall = 1'b0;
        pop_pc.delete();
        pop_inst.delete();
        repeat (12) tick();
        checks++;
        if (pop_pc.size() < 10) begin
            errors++;
            $display("FAIL stall_resume_count: got %0d words, want >= 10", pop_pc.size());
        end
        foreach (pop_pc[i]) begin
            checks++;
            if (pop_pc[i] !== hold_pc + 32'(4 * i) || pop_inst[i] !== memf(pop_pc[i])) begin
                errors++;
                $display("FAIL stall_resume i=%0d: got pc=%h inst=%h, want %h %h",
                         i, pop_pc[i], pop_inst[i], hold_pc + 32'(4 * i), memf(hold_pc + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_redirect();
        bit ok;
        bit seen;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL redirect_drain: got not drained, want drained within 40 cycles"); end
        g_lat = 3; g_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (pend.size() != 2) begin
            errors++;
            $display("FAIL redirect_setup: got %0d outstanding, want 2", pend.size());
        end
        g_redir = 1'b1; g_redir_pc = 32'h0000_0100;
        tick();
        g_redir = 1'b0;
        checks++;
        if (s_req_valid !== 1'b0) begin errors++; $display("FAIL redirect_noissue: got req_valid=%b, want 0", s_req_valid); end
        pop_pc.delete();
        pop_inst.delete();
        seen = 1'b0;
        for (int i = 0; i < 30 && pop_pc.size() < 2; i++) begin
            tick();
            if (!seen && s_if_valid) begin
                seen = 1'b1;
                checks++;
                if (s_if_pc !== 32'h100) begin
                    errors++;
                    $display("FAIL redirect_first_valid: got pc=%h, want 00000100", s_if_pc);
                end
            end
        end
        checks++;
        if (pop_pc.size() < 2) begin
            errors++;
            $display("FAIL redirect_timeout: got %0d words, want 2", pop_pc.size());
        end else if (pop_pc[0] !== 32'h100 || pop_pc[1] !== 32'h104 ||
                     pop_inst[0] !== memf(32'h100) || pop_inst[1] !== memf(32'h104)) begin
            errors++;
            $display("FAIL redirect_words: got %h/%h %h/%h, want 00000100/%h 00000104/%h",
                     pop_pc[0], pop_inst[0], pop_pc[1], pop_inst[1], memf(32'h100), memf(32'h104));
        end
    endtask

    task automatic test_redirect_rsp();
        bit ok;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rsp_drain: got not drained, want drained within 40 cycles"); end
        g_lat = 2; g_ready = 1'b1;
        repeat (2) tick();
        g_redir = 1'b1; g_redir_pc = 32'h0000_2000;
        tick();
        g_redir = 1'b0;
        checks++;
        if (s_rsp !== 1'b1 || pend.size() != 1) begin
            errors++;
            $display("FAIL rsp_same_cycle: got rsp=%b left=%0d, want 1 1", s_rsp, pend.size());
        end
        pop_pc.delete();
        pop_inst.delete();
        repeat (20) tick();
        checks++;
        if (pop_pc.size() < 4) begin
            errors++;
            $display("FAIL rsp_count: got %0d words, want >= 4", pop_pc.size());
        end
        foreach (pop_pc[i]) begin
            checks++;
            if (pop_pc[i] !== 32'h2000 + 32'(4 * i) || pop_inst[i] !== memf(pop_pc[i])) begin
                errors++;
                $display("FAIL rsp_stream i=%0d: got pc=%h inst=%h, want %h %h",
                         i, pop_pc[i], pop_inst[i], 32'h2000 + 32'(4 * i), memf(32'h2000 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_ready_low();
        logic [31:0] want;
        want    = last_acc + 32'd4;
        g_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_req_valid !== 1'b1 || s_addr !== want) begin
                errors++;
                $display("FAIL ready_low i=%0d: got req_valid=%b addr=%h, want 1 %h", i, s_req_valid, s_addr, want);
            end
        end
        g_ready = 1'b1;
        tick();
        checks++;
        if (s_accept !== 1'b1 || s_addr !== want) begin
            errors++;
            $display("FAIL ready_resume: got accept=%b addr=%h, want 1 %h", s_accept, s_addr, want);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_issue, p_pc, p_inst;
        logic        p_hold;
        g_stall = 1'b0; g_ready = 1'b1; g_redir = 1'b1; g_redir_pc = 32'h0000_4000;
        tick();
        exp_pc = 32'h4000; exp_issue = 32'h4000; p_hold = 1'b0; p_pc = '0; p_inst = '0;
        for (int n = 0; n < 400; n++) begin
            g_stall    = ($urandom_range(0, 99) < 30);
            g_ready    = ($urandom_range(0, 99) < 70);
            g_redir    = ($urandom_range(0, 99) < 4);
            g_lat      = int'($urandom_range(1, 4));
            g_redir_pc = $urandom & 32'hFFFF_FFFC;
            tick();
            if (g_redir) begin
                checks++;
                if (s_req_valid !== 1'b0) begin errors++; $display("FAIL rnd_redir_req n=%0d: got 1, want 0", n); end
            end
            if (s_accept) begin
                checks++;
                if (s_addr !== exp_issue) begin
                    errors++;
                    $display("FAIL rnd_addr n=%0d: got %h, want %h", n, s_addr, exp_issue);
                end
                exp_issue = exp_issue + 32'd4;
            end
            if (!s_if_valid) begin
                checks++;
                if (s_if_pc !== 32'h0 || s_if_inst !== NOP_W) begin
                    errors++;
                    $display("FAIL rnd_bubble n=%0d: got pc=%h inst=%h, want 0 %h", n, s_if_pc, s_if_inst, NOP_W);
                end
            end else if (s_pop) begin
                checks++;
                if (s_if_pc !== exp_pc || s_if_inst !== memf(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_word n=%0d: got pc=%h inst=%h, want %h %h", n, s_if_pc, s_if_inst, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (p_hold) begin
                checks++;
                if (s_if_valid !== 1'b1 || s_if_pc !== p_pc || s_if_inst !== p_inst) begin
                    errors++;
                    $display("FAIL rnd_hold n=%0d: got valid=%b pc=%h inst=%h, want 1 %h %h",
                             n, s_if_valid, s_if_pc, s_if_inst, p_pc, p_inst);
                end
            end
            checks++;
            if (pend.size() > DA) begin
                errors++;
                $display("FAIL rnd_outstanding n=%0d: got %0d, want <= %0d", n, pend.size(), DA);
            end
            if (g_redir) begin
                exp_pc    = g_redir_pc;
                exp_issue = g_redir_pc;
            end
            p_hold = s_if_valid && g_stall && !g_redir;
            p_pc   = s_if_pc;
            p_inst = s_if_inst;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        rst_a = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (8) tick_b();
        checks++;
        if (b_acc.size() < 3 || b_pop_pc.size() < 3) begin
            errors++;
            $display("FAIL wrap_count: got %0d accepts %0d words, want >= 3 each", b_acc.size(), b_pop_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (b_acc[i] !== want[i] || b_pop_pc[i] !== want[i] || b_pop_inst[i] !== memf(want[i])) begin
                    errors++;
                    $display("FAIL wrap_seq i=%0d: got addr=%h pc=%h inst=%h, want %h %h %h",
                             i, b_acc[i], b_pop_pc[i], b_pop_inst[i], want[i], want[i], memf(want[i]));
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            if (b_if_valid) break;
            tick_b();
        end
        checks++;
        if (b_if_valid !== 1'b1) begin errors++; $display("FAIL wrap_prereset: got if_valid=%b, want 1", b_if_valid); end
        #1;
        rst_b = 1'b0;
        #1;
        checks++;
        if (b_if_valid !== 1'b0 || b_req_valid !== 1'b0 || b_if_pc !== 32'h0 || b_if_inst !== NOP_W) begin
            errors++;
            $display("FAIL wrap_async_reset: got if_valid=%b req_valid=%b pc=%h inst=%h, want 0 0 0 %h",
                     b_if_valid, b_req_valid, b_if_pc, b_if_inst, NOP_W);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; g_lat = 1;
        g_stall = 1'b0; g_redir = 1'b0; g_ready = 1'b0; g_redir_pc = '0;
        exp_pc = '0; last_acc = '0;
        rst_a = 1'b0; a_stall = 1'b0; a_redir = 1'b0; a_redir_pc = '0; a_ready = 1'b0;
        a_rsp_valid = 1'b0; a_rsp_data = '0;
        rst_b = 1'b0; b_stall = 1'b0; b_redir = 1'b0; b_redir_pc = '0; b_ready = 1'b0;
        b_rsp_valid = 1'b0; b_rsp_data = '0; b_prev_acc = 1'b0; b_prev_addr = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_rsp();
        test_ready_low();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time=%0t, want finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that produces the `if_pc`/`if_inst` pair consumed by the IF/ID pipeline register. It is the producer end of that interface.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready channel. Returned words are buffered in a small FIFO.
- Honours `stall` from the hazard unit and `redirect` from branch resolution, dropping stale in-flight responses.
- When it has nothing valid to present, it drives a NOP bubble, because the IF/ID register carries no valid bit.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction-buffer entries and max outstanding+buffered requests; power of 2, >=2.
- NOP, 32'h0000_0013, bubble word (addi x0,x0,0) driven when no valid instruction.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  downstream holding; do not pop buffer head.
- redirect  in  1  control-flow change this cycle.
- redirect_pc  in  32  new fetch address, valid with redirect; word-aligned.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  request address.
- imem_rsp_valid  in  1  response word valid; in order, never backpressured.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  buffer head valid.
- if_pc  out  32  PC of head; 0 when !if_valid.
- if_inst  out  32  instruction of head; NOP when !if_valid.

Behaviour:
State registers:
- pc: next issue address.
- rsp_pc: PC tag of the next kept response.
- outstanding: 0..DEPTH.
- drop_cnt: 0..DEPTH.
- FIFO: DEPTH entries of {pc, inst}, with count.

Reset (reset=0, async):
- pc=rsp_pc=RESET_PC.
- outstanding=drop_cnt=count=0.
- Outputs are then: imem_req_valid=0, if_valid=0, if_pc=0, if_inst=NOP.

Issue and response:
- imem_req_valid = !redirect && (outstanding+count < DEPTH); imem_addr = pc (combinational from state).
- issue = imem_req_valid && imem_req_ready; on issue pc <= pc+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
- Response handling:
  - drop_cnt>0 or redirect same cycle: response discarded; drop_cnt decrements (if no redirect).
  - Otherwise: push {rsp_pc, imem_rsp_data}; rsp_pc <= rsp_pc+4.
  - The credit rule guarantees the FIFO never overflows; no full-drop path exists.

Output and pop:
- if_valid = count!=0; if_pc/if_inst = FIFO head (combinational).
- pop = if_valid && !stall && !redirect. Same-cycle push+pop on an empty FIFO does not bypass; the word appears next cycle.
- Latency: request accepted in cycle N, response in N+k; visible on if_* at N+k+1.

Counter update:
- outstanding_next = outstanding + issue - imem_rsp_valid.

Redirect (highest priority):
- pc <= redirect_pc; rsp_pc <= redirect_pc; FIFO cleared (count=0); no issue and no pop this cycle.
- drop_cnt <= outstanding - imem_rsp_valid, so every in-flight stale response is dropped.
- Fetch resumes at redirect_pc the following cycle.

Stall:
- Head is held stable and issue continues until credits are exhausted.
- stall and redirect together: redirect wins.

Test Plan:
1. Reset release, memory always ready, 1-cycle response latency, `stall`=0:
   - Required: imem_addr sequence 0,4,8,...
   - Required: if_valid rises 2 cycles after the first accept, then if_pc steps by 4 every cycle with matching data.
2. `stall` held for 5 cycles while streaming:
   - Required: if_pc/if_inst frozen for all 5 cycles.
   - Required: at most DEPTH requests outstanding+buffered, then imem_req_valid=0.
   - Required: stream resumes with no word lost or duplicated.
3. `redirect` to 32'h100 with 2 outstanding responses:
   - Required: both stale responses are dropped and if_valid is 0 until the word for 0x100 arrives.
   - Required: the next if_pc is 32'h100, then 32'h104.
4. `redirect` in the same cycle as `imem_rsp_valid`:
   - Required: that response is dropped and drop_cnt = outstanding-1.
   - Required: no stale PC ever appears on if_pc.
5. imem_req_ready low for 3 cycles:
   - Required: imem_req_valid stays 1 and imem_addr is held constant; no pc advance.
6. RESET_PC=32'hFFFF_FFF8 streaming:
   - Required: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
   - Required: asserting `reset` mid-stream immediately clears if_valid and imem_req_valid.
